// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: averages mic samples into ping-pong frames and streams each completed frame to the FFT.
module fft_frame_buffer #(
  parameter int LOG2_N = 8,
  parameter int DECIM_LOG2 = 2
) (
  input  logic        clock_27mhz,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        sample_ready,
  input  logic [15:0] sample_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        overrun,
  output logic [7:0]  frame_count
);
  localparam int N = 1 << LOG2_N;
  localparam int AW = 16 + DECIM_LOG2;
  localparam int DW = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
  localparam logic [DW-1:0] DLAST = DW'((1 << DECIM_LOG2) - 1);
  localparam logic [LOG2_N-1:0] NLAST = '1;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t state, state_d;
  logic [15:0] mem [2*N];
  logic signed [AW-1:0] acc, sum;
  logic [15:0] wdata;
  logic [DW-1:0] dcnt;
  logic [LOG2_N-1:0] waddr, rptr, raddr;
  logic wsel, wr, done, xfer, end_beat, free, launch;
  assign sum = acc + AW'($signed(sample_data));
  assign wdata = 16'(sum >>> DECIM_LOG2);
  assign wr = capture_en & sample_ready & (dcnt == DLAST);
  assign done = wr & (waddr == NLAST);
  assign xfer = out_valid & out_ready;
  assign end_beat = xfer & (rptr == NLAST);
  assign free = (state == IDLE) | end_beat;
  assign launch = done & free;
  // rptr is 0 throughout LOAD, so this also covers the initial read of beat 0
  assign raddr = xfer ? rptr + 1'b1 : rptr;
  always_comb begin
    state_d = state == LOAD ? STREAM : launch ? LOAD : (state == STREAM && !end_beat) ? STREAM : IDLE;
    out_valid = state == STREAM;
    out_first = out_valid && rptr == '0;
    out_last = out_valid && rptr == NLAST;
  end
  always_ff @(posedge clock_27mhz)
    if (wr) mem[{wsel, waddr}] <= wdata;
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      state <= IDLE;
      wsel <= 1'b0;
      waddr <= '0;
      dcnt <= '0;
      acc <= '0;
      rptr <= '0;
      out_data <= '0;
      overrun <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_d;
      out_data <= mem[{~wsel, raddr}];
      if (!capture_en) begin
        waddr <= '0;
        dcnt <= '0;
        acc <= '0;
      end else if (sample_ready) begin
        dcnt <= wr ? '0 : dcnt + 1'b1;
        acc <= wr ? '0 : sum;
        if (wr) waddr <= waddr + 1'b1;
      end
      if (launch) wsel <= ~wsel;
      if (done && !free) overrun <= 1'b1;
      if (launch) rptr <= '0;
      else if (xfer) rptr <= rptr + 1'b1;
      if (end_beat) frame_count <= frame_count + 1'b1;
    end
  end
endmodule
